div_seq: RTL and testbench

- Sequential unsigned integer divider, the inverse of the team's sequential multiplier.
- Shares that block's START/DONE handshake and LEN-bit operand style.
- Restoring algorithm, radix-2: one quotient bit per clock, so fixed latency of LEN cycles.
- Drop-in arithmetic peripheral beside the multiplier in datapath builds.

---
 rtl/div_seq.sv | 103 ++++++++++
 tb/tb_div_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: sequential restoring radix-2 divider, one quotient bit per clock, fixed LEN-cycle latency.
// Build options: DIV_SIGNED_EN selects two's-complement operands; the LEN parameter sets the width.

module div_seq #(
  parameter int unsigned LEN = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [LEN-1:0] i_a,
  input  logic [LEN-1:0] i_b,
  output logic           o_done,
  output logic [LEN-1:0] o_q,
  output logic [LEN-1:0] o_r
);

  localparam int unsigned CW = $clog2(LEN + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         r_state;
  logic [LEN-1:0] r_divisor;
  logic [LEN-1:0] r_rem;
  logic [LEN-1:0] r_quo;
  logic [LEN-1:0] r_q;
  logic [LEN-1:0] r_r;
  logic [CW-1:0]  r_count;

  logic [LEN-1:0] w_loadA;
  logic [LEN-1:0] w_loadB;
  logic [LEN:0]   w_shift;
  logic           w_ge;
  logic [LEN-1:0] w_remNext;
  logic [LEN-1:0] w_quoNext;
  logic [LEN-1:0] w_qFinal;
  logic [LEN-1:0] w_rFinal;

  // The shifted remainder is LEN+1 bits wide so its carry-out still takes part in the compare;
  // when the compare succeeds the true difference is below the divisor, so LEN-bit subtraction is exact.
  assign w_shift   = {r_rem, r_quo[LEN-1]};
  assign w_ge      = (w_shift >= {1'b0, r_divisor});
  assign w_remNext = w_ge ? (w_shift[LEN-1:0] - r_divisor) : w_shift[LEN-1:0];
  assign w_quoNext = {r_quo[LEN-2:0], w_ge};

`ifdef DIV_SIGNED_EN
  logic r_negQ;
  logic r_negR;

  assign w_loadA  = i_a[LEN-1] ? ('0 - i_a) : i_a;
  assign w_loadB  = i_b[LEN-1] ? ('0 - i_b) : i_b;
  assign w_qFinal = r_negQ ? ('0 - w_quoNext) : w_quoNext;
  assign w_rFinal = r_negR ? ('0 - w_remNext) : w_remNext;
`else
  assign w_loadA  = i_a;
  assign w_loadB  = i_b;
  assign w_qFinal = w_quoNext;
  assign w_rFinal = w_remNext;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_q       <= '0;
      r_r       <= '0;
      r_count   <= '0;
`ifdef DIV_SIGNED_EN
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
`endif
    end else if (i_start) begin
      r_divisor <= w_loadB;
      r_quo     <= w_loadA;
      r_rem     <= '0;
      r_count   <= CW'(LEN);
      r_state   <= BUSY;
`ifdef DIV_SIGNED_EN
      // A zero divisor keeps the quotient at all ones, so it is never negated.
      r_negQ    <= (i_a[LEN-1] ^ i_b[LEN-1]) && (i_b != '0);
      r_negR    <= i_a[LEN-1];
`endif
    end else if (r_state == BUSY) begin
      r_rem   <= w_remNext;
      r_quo   <= w_quoNext;
      r_count <= r_count - CW'(1);
      if (r_count == CW'(1)) begin
        r_q     <= w_qFinal;
        r_r     <= w_rFinal;
        r_state <= IDLE;
      end
    end
  end

  assign o_done = (r_state == IDLE);
  assign o_q    = r_q;
  assign o_r    = r_r;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized and directed checks of div_seq against an arithmetic reference model.
// Build with DIV_SIGNED_EN defined to exercise the two's-complement variant.

module tb_div_seq;

  localparam int LEN     = 16;
  localparam int MAXWAIT = 4 * LEN;

  logic           clk = 1'b0;
  logic           rstN;
  logic           start;
  logic [LEN-1:0] a;
  logic [LEN-1:0] b;
  logic           done;
  logic [LEN-1:0] q;
  logic [LEN-1:0] r;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  div_seq #(.LEN(LEN)) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .o_done  (done),
    .o_q     (q),
    .o_r     (r)
  );

  // Single comparison point: counts every check and reports any difference
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference division straight from the arithmetic definition
  function automatic void refDiv(input logic [LEN-1:0] da, input logic [LEN-1:0] db,
                                 output logic [LEN-1:0] rq, output logic [LEN-1:0] rr);
`ifdef DIV_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(da));
    sb = longint'($signed(db));
    if (sb == 0) begin
      rq = '1;
      rr = da;
    end else begin
      rq = LEN'(sa / sb);
      rr = LEN'(sa % sb);
    end
`else
    if (db == '0) begin
      rq = '1;
      rr = da;
    end else begin
      rq = da / db;
      rr = da % db;
    end
`endif
  endfunction

  // Runs one division; with restartAt > 0 a second START (a1,b1) interrupts after that many cycles
  task automatic applyStimulus(input logic [LEN-1:0] a0, input logic [LEN-1:0] b0,
                               input int restartAt,
                               input logic [LEN-1:0] a1, input logic [LEN-1:0] b1,
                               input string tag);
    logic [LEN-1:0] expQ;
    logic [LEN-1:0] expR;
    logic [LEN-1:0] heldQ;
    logic [LEN-1:0] heldR;
    logic           holdOk;
    int             cycles;
    heldQ  = q;
    heldR  = r;
    holdOk = 1'b1;
    @(negedge clk);
    a = a0; b = b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = LEN'($urandom); b = LEN'($urandom);
    if (restartAt > 0) begin
      for (int i = 0; i < restartAt; i++) begin
        if (done || q !== heldQ || r !== heldR) holdOk = 1'b0;
        @(negedge clk);
      end
      a = a1; b = b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = LEN'($urandom); b = LEN'($urandom);
      refDiv(a1, b1, expQ, expR);
    end else begin
      refDiv(a0, b0, expQ, expR);
    end
    cycles = 1;
    while (!done && cycles < MAXWAIT) begin
      if (q !== heldQ || r !== heldR) holdOk = 1'b0;
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, ".latency"}, 64'(cycles - 1), 64'(LEN));
    checkOutput({tag, ".hold"}, 64'(holdOk), 64'd1);
    checkOutput({tag, ".q"}, 64'(q), 64'(expQ));
    checkOutput({tag, ".r"}, 64'(r), 64'(expR));
  endtask

  initial begin
    logic [LEN-1:0] ra;
    logic [LEN-1:0] rb;
    logic [LEN-1:0] expQ;
    logic [LEN-1:0] expR;
    logic           busyOk;
    int             cycles;

    rstN = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("reset.done", 64'(done), 64'd1);
    checkOutput("reset.q", 64'(q), 64'd0);
    checkOutput("reset.r", 64'(r), 64'd0);

    applyStimulus(16'd100, 16'd7, 0, '0, '0, "basic");
    checkOutput("basic.qConst", 64'(q), 64'd14);
    checkOutput("basic.rConst", 64'(r), 64'd2);
    applyStimulus(16'hFFFF, 16'd1, 0, '0, '0, "divOne");
    applyStimulus(16'h1234, 16'd0, 0, '0, '0, "divZero");
    checkOutput("divZero.qConst", 64'(q), 64'hFFFF);
    checkOutput("divZero.rConst", 64'(r), 64'h1234);
    applyStimulus(16'd5, 16'h9000, 0, '0, '0, "aLessB");
    applyStimulus(16'hF000, 16'h8001, 0, '0, '0, "carryOut");
`ifndef DIV_SIGNED_EN
    checkOutput("carryOut.qConst", 64'(q), 64'd1);
    checkOutput("carryOut.rConst", 64'(r), 64'h6FFF);
`endif
    applyStimulus(16'd0, 16'd3, 0, '0, '0, "zeroA");

    applyStimulus(16'd1000, 16'd3, 8, 16'd50, 16'd6, "restart");
    checkOutput("restart.qConst", 64'(q), 64'd8);
    checkOutput("restart.rConst", 64'(r), 64'd2);

    // Abort a running division with reset; the earlier non-zero result must vanish
    @(negedge clk);
    a = 16'd1000; b = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    checkOutput("midReset.done", 64'(done), 64'd1);
    checkOutput("midReset.q", 64'(q), 64'd0);
    checkOutput("midReset.r", 64'(r), 64'd0);
    applyStimulus(16'd9, 16'd4, 0, '0, '0, "afterReset");
    checkOutput("afterReset.qConst", 64'(q), 64'd2);
    checkOutput("afterReset.rConst", 64'(r), 64'd1);

    // START held high reloads each edge; only the last operands count
    busyOk = 1'b1;
    ra = '0; rb = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0 && done) busyOk = 1'b0;
      ra = LEN'($urandom); rb = LEN'($urandom_range(1, 500));
      a = ra; b = rb; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    if (done) busyOk = 1'b0;
    refDiv(ra, rb, expQ, expR);
    cycles = 1;
    while (!done && cycles < MAXWAIT) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("heldStart.busy", 64'(busyOk), 64'd1);
    checkOutput("heldStart.latency", 64'(cycles - 1), 64'(LEN));
    checkOutput("heldStart.q", 64'(q), 64'(expQ));
    checkOutput("heldStart.r", 64'(r), 64'(expR));

`ifdef DIV_SIGNED_EN
    applyStimulus(16'hFFF9, 16'd2, 0, '0, '0, "sNegA");
    checkOutput("sNegA.qConst", 64'(q), 64'hFFFD);
    checkOutput("sNegA.rConst", 64'(r), 64'hFFFF);
    applyStimulus(16'h8000, 16'hFFFF, 0, '0, '0, "sOverflow");
    checkOutput("sOverflow.qConst", 64'(q), 64'h8000);
    checkOutput("sOverflow.rConst", 64'(r), 64'h0000);
    applyStimulus(16'd7, 16'hFFFE, 0, '0, '0, "sNegB");
    checkOutput("sNegB.qConst", 64'(q), 64'hFFFD);
    checkOutput("sNegB.rConst", 64'(r), 64'h0001);
    applyStimulus(16'hFF00, 16'd0, 0, '0, '0, "sDivZero");
`endif

    for (int n = 0; n < 40; n++) begin
      ra = LEN'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = LEN'($urandom_range(1, 15));
        2:       rb = LEN'($urandom) | 16'h8000;
        3:       rb = ra;
        default: rb = LEN'($urandom);
      endcase
      applyStimulus(ra, rb, 0, '0, '0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
